// File: rtl/pc_redirect_ctrl.sv
// PC redirect controller: arbitrates trap / mret / branch redirects into the
// PC counter, parks a redirect while fetch is busy, and handles debug halt.
module pc_redirect_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  bru_taken_i,
    input  logic [DATA_WIDTH-1:0] bru_target_i,
    input  logic                  trap_req_i,
    input  logic [DATA_WIDTH-1:0] trap_pc_i,
    input  logic [DATA_WIDTH-1:0] mtvec_i,
    input  logic                  mret_i,
    input  logic [DATA_WIDTH-1:0] mepc_i,
    input  logic                  hazard_stall_i,
    input  logic                  fetch_ready_i,
    input  logic                  halt_req_i,
    input  logic                  resume_i,
    output logic                  stall_o,
    output logic                  is_taken_o,
    output logic [DATA_WIDTH-1:0] bru_pc_o,
    output logic                  flush_o,
    output logic                  trap_ack_o,
    output logic [DATA_WIDTH-1:0] epc_o,
    output logic                  halted_o,
    output logic [15:0]           redirect_cnt_o
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PEND = 2'd1,
        HALT = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] pend_q, pend_d;
    logic [DATA_WIDTH-1:0] epc_q, epc_d;
    logic                  halt_def_q, halt_def_d;
    logic [15:0]           cnt_q, cnt_d;

    logic                  sel_trap;
    logic                  sel_mret;
    logic                  sel_br;
    logic                  sel_req;
    logic [DATA_WIDTH-1:0] sel_tgt;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Request selection: trap beats mret beats branch; only traps are seen in HALT.
    always_comb begin
        sel_trap = trap_req_i;
        sel_mret = ~trap_req_i & mret_i & (state_q == RUN);
        sel_br   = ~trap_req_i & ~mret_i & bru_taken_i & (state_q == RUN);
        sel_req  = sel_trap | sel_mret | sel_br;
        if (sel_trap) begin
            sel_tgt = mtvec_i;
        end else if (sel_mret) begin
            sel_tgt = mepc_i;
        end else begin
            sel_tgt = bru_target_i;
        end
    end

    // Next-state and redirect outputs; reset masks every redirect strobe.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        halt_def_d = halt_def_q;
        is_taken_o = 1'b0;
        flush_o    = 1'b0;
        trap_ack_o = 1'b0;
        bru_pc_o   = sel_tgt;

        case (state_q)
            RUN, HALT: begin
                if (sel_req) begin
                    flush_o    = 1'b1;
                    trap_ack_o = sel_trap;
                    if (fetch_ready_i) begin
                        is_taken_o = 1'b1;
                        state_d    = RUN;
                    end else begin
                        pend_d  = sel_tgt;
                        state_d = PEND;
                    end
                end else if (state_q == HALT) begin
                    if (resume_i) begin
                        state_d = RUN;
                    end
                end else if (halt_req_i) begin
                    state_d = HALT;
                end
            end
            PEND: begin
                // A trap arriving while parked replaces the stale target outright.
                bru_pc_o   = trap_req_i ? mtvec_i : pend_q;
                is_taken_o = fetch_ready_i;
                if (trap_req_i) begin
                    flush_o    = 1'b1;
                    trap_ack_o = 1'b1;
                    pend_d     = mtvec_i;
                end
                if (fetch_ready_i) begin
                    state_d    = (halt_def_q | halt_req_i) ? HALT : RUN;
                    halt_def_d = 1'b0;
                end else begin
                    halt_def_d = halt_def_q | halt_req_i;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (rst_i) begin
            is_taken_o = 1'b0;
            flush_o    = 1'b0;
            trap_ack_o = 1'b0;
            state_d    = RUN;
            pend_d     = '0;
            halt_def_d = 1'b0;
        end
    end

    // Trap PC capture and saturating redirect count.
    always_comb begin
        epc_d = trap_ack_o ? trap_pc_i : epc_q;
        cnt_d = is_taken_o ? sat_inc16(cnt_q) : cnt_q;
    end

    // State, pending target, trap PC and counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            pend_q     <= '0;
            halt_def_q <= 1'b0;
            epc_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            halt_def_q <= halt_def_d;
            epc_q      <= epc_d;
            cnt_q      <= cnt_d;
        end
    end

    assign stall_o        = (hazard_stall_i | ~fetch_ready_i | (state_q == HALT)) & ~is_taken_o;
    assign halted_o       = (state_q == HALT);
    assign epc_o          = epc_q;
    assign redirect_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Testbench for pc_redirect_ctrl: directed cycle table, randomized run against
// a behavioural model, and a counter saturation sequence.
module tb_pc_redirect_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_i, bru_taken_i, trap_req_i, mret_i;
    logic         hazard_stall_i, fetch_ready_i, halt_req_i, resume_i;
    logic [W-1:0] bru_target_i, trap_pc_i, mtvec_i, mepc_i;
    logic         stall_o, is_taken_o, flush_o, trap_ack_o, halted_o;
    logic [W-1:0] bru_pc_o, epc_o;
    logic [15:0]  redirect_cnt_o;

    always #5 clk = ~clk;

    pc_redirect_ctrl #(.DATA_WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .bru_taken_i(bru_taken_i), .bru_target_i(bru_target_i),
        .trap_req_i(trap_req_i), .trap_pc_i(trap_pc_i), .mtvec_i(mtvec_i),
        .mret_i(mret_i), .mepc_i(mepc_i),
        .hazard_stall_i(hazard_stall_i), .fetch_ready_i(fetch_ready_i),
        .halt_req_i(halt_req_i), .resume_i(resume_i),
        .stall_o(stall_o), .is_taken_o(is_taken_o), .bru_pc_o(bru_pc_o),
        .flush_o(flush_o), .trap_ack_o(trap_ack_o), .epc_o(epc_o),
        .halted_o(halted_o), .redirect_cnt_o(redirect_cnt_o)
    );

    typedef struct {
        logic rst, tk; logic [W-1:0] tgt;
        logic trap; logic [W-1:0] tpc, mtvec;
        logic mret; logic [W-1:0] mepc;
        logic hz, rdy, halt, res;
    } in_t;

    typedef struct {
        in_t i;
        logic stall, taken; logic [W-1:0] pc;
        logic flush, ack; logic [W-1:0] epc;
        logic halted; logic [15:0] cnt;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state: "parked redirect", "halted", "halt deferred".
    bit m_pend, m_halt, m_defer;
    logic [W-1:0] m_tgt, m_epc;
    int m_cnt;
    logic e_stall, e_taken, e_flush, e_ack, e_halted;
    logic [W-1:0] e_pc, e_epc;
    logic [15:0] e_cnt;

    function automatic vec_t mk(input logic rst, tk, input logic [W-1:0] tgt,
                                input logic trap, input logic [W-1:0] tpc, mtvec,
                                input logic mret, input logic [W-1:0] mepc,
                                input logic hz, rdy, halt, res,
                                input logic stall, taken, input logic [W-1:0] pc,
                                input logic flush, ack, input logic [W-1:0] epc,
                                input logic halted, input logic [15:0] cnt);
        vec_t v;
        v.i.rst = rst; v.i.tk = tk; v.i.tgt = tgt; v.i.trap = trap; v.i.tpc = tpc;
        v.i.mtvec = mtvec; v.i.mret = mret; v.i.mepc = mepc; v.i.hz = hz;
        v.i.rdy = rdy; v.i.halt = halt; v.i.res = res;
        v.stall = stall; v.taken = taken; v.pc = pc; v.flush = flush; v.ack = ack;
        v.epc = epc; v.halted = halted; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input in_t x);
        logic [W-1:0] t;
        bit req;
        bit n_pend, n_halt, n_defer;
        logic [W-1:0] n_tgt, n_epc;
        int n_cnt;
        n_pend = m_pend; n_halt = m_halt; n_defer = m_defer;
        n_tgt = m_tgt; n_epc = m_epc; n_cnt = m_cnt;
        e_halted = m_halt; e_epc = m_epc; e_cnt = m_cnt[15:0];
        e_taken = 1'b0; e_flush = 1'b0; e_ack = 1'b0; e_pc = '0;
        if (x.rst) begin
            n_pend = 0; n_halt = 0; n_defer = 0; n_tgt = '0; n_epc = '0; n_cnt = 0;
        end else if (m_pend) begin
            t = x.trap ? x.mtvec : m_tgt;
            e_pc = t; e_taken = x.rdy; e_flush = x.trap; e_ack = x.trap;
            if (x.rdy) begin
                n_pend = 0; n_halt = m_defer || x.halt; n_defer = 0;
            end else begin
                n_tgt = t; n_defer = m_defer || x.halt;
            end
        end else begin
            if (x.trap) t = x.mtvec;
            else if (!m_halt && x.mret) t = x.mepc;
            else t = x.tgt;
            req = x.trap || (!m_halt && (x.mret || x.tk));
            if (req) begin
                e_flush = 1'b1; e_ack = x.trap; n_halt = 0;
                if (x.rdy) begin e_taken = 1'b1; e_pc = t; end
                else begin n_pend = 1; n_tgt = t; end
            end else if (m_halt) begin
                if (x.res) n_halt = 0;
            end else if (x.halt) begin
                n_halt = 1;
            end
        end
        e_stall = (x.hz || !x.rdy || m_halt) && !e_taken;
        if (!x.rst) begin
            if (e_ack) n_epc = x.tpc;
            if (e_taken && m_cnt < 65535) n_cnt = m_cnt + 1;
        end
        m_pend = n_pend; m_halt = n_halt; m_defer = n_defer;
        m_tgt = n_tgt; m_epc = n_epc; m_cnt = n_cnt;
    endtask

    // Drive one cycle's inputs after the falling edge, then let outputs settle.
    task automatic step(input in_t x);
        @(negedge clk);
        rst_i = x.rst; bru_taken_i = x.tk; bru_target_i = x.tgt;
        trap_req_i = x.trap; trap_pc_i = x.tpc; mtvec_i = x.mtvec;
        mret_i = x.mret; mepc_i = x.mepc; hazard_stall_i = x.hz;
        fetch_ready_i = x.rdy; halt_req_i = x.halt; resume_i = x.res;
        #2;
        model_step(x);
    endtask

    vec_t tbl[34];
    in_t  x;

    initial begin
        tbl[0]  = mk(1,1,'h100,1,'h44,'h80,0,0,0,1,0,0, 0,0,0,0,0,0,0,0);
        tbl[1]  = mk(0,1,'h100,0,0,0,0,0,0,1,0,0, 0,1,'h100,1,0,0,0,0);
        tbl[2]  = mk(0,0,0,0,0,0,0,0,0,1,0,0, 0,0,0,0,0,0,0,1);
        tbl[3]  = mk(0,1,'h300,1,'h44,'h80,0,0,0,1,0,0, 0,1,'h80,1,1,0,0,1);
        tbl[4]  = mk(0,0,0,0,0,0,0,0,0,1,0,0, 0,0,0,0,0,'h44,0,2);
        tbl[5]  = mk(0,1,'h200,0,0,0,0,0,0,0,0,0, 1,0,0,1,0,'h44,0,2);
        tbl[6]  = mk(0,0,0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,'h44,0,2);
        tbl[7]  = mk(0,0,0,0,0,0,1,'h500,0,0,0,0, 1,0,0,0,0,'h44,0,2);
        tbl[8]  = mk(0,0,0,0,0,0,0,0,0,1,0,0, 0,1,'h200,0,0,'h44,0,2);
        tbl[9]  = mk(0,0,0,0,0,0,0,0,1,1,0,0, 1,0,0,0,0,'h44,0,3);
        tbl[10] = mk(0,1,'h200,0,0,0,0,0,0,0,0,0, 1,0,0,1,0,'h44,0,3);
        tbl[11] = mk(0,0,0,1,'h60,'h80,0,0,0,0,0,0, 1,0,0,1,1,'h44,0,3);
        tbl[12] = mk(0,0,0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,'h60,0,3);
        tbl[13] = mk(0,0,0,0,0,0,0,0,0,1,0,0, 0,1,'h80,0,0,'h60,0,3);
        tbl[14] = mk(0,0,0,0,0,0,0,0,0,1,0,0, 0,0,0,0,0,'h60,0,4);
        tbl[15] = mk(0,0,0,0,0,0,0,0,0,1,1,0, 0,0,0,0,0,'h60,0,4);
        tbl[16] = mk(0,1,'h700,0,0,0,0,0,0,1,0,0, 1,0,0,0,0,'h60,1,4);
        tbl[17] = mk(0,0,0,0,0,0,0,0,0,1,0,1, 1,0,0,0,0,'h60,1,4);
        tbl[18] = mk(0,0,0,0,0,0,0,0,1,1,0,0, 1,0,0,0,0,'h60,0,4);
        tbl[19] = mk(0,0,0,0,0,0,0,0,0,1,0,0, 0,0,0,0,0,'h60,0,4);
        tbl[20] = mk(0,0,0,0,0,0,0,0,0,1,1,0, 0,0,0,0,0,'h60,0,4);
        tbl[21] = mk(0,0,0,1,'h70,'h90,0,0,0,1,0,1, 0,1,'h90,1,1,'h60,1,4);
        tbl[22] = mk(0,0,0,0,0,0,0,0,0,1,0,0, 0,0,0,0,0,'h70,0,5);
        tbl[23] = mk(0,1,'h200,0,0,0,0,0,0,0,0,0, 1,0,0,1,0,'h70,0,5);
        tbl[24] = mk(1,1,'h300,0,0,0,0,0,0,1,0,0, 0,0,0,0,0,'h70,0,5);
        tbl[25] = mk(0,0,0,0,0,0,0,0,0,1,0,0, 0,0,0,0,0,0,0,0);
        tbl[26] = mk(0,1,'h10,0,0,0,0,0,0,0,0,0, 1,0,0,1,0,0,0,0);
        tbl[27] = mk(0,0,0,0,0,0,0,0,0,0,1,0, 1,0,0,0,0,0,0,0);
        tbl[28] = mk(0,0,0,0,0,0,0,0,0,1,0,0, 0,1,'h10,0,0,0,0,0);
        tbl[29] = mk(0,0,0,0,0,0,0,0,0,1,0,0, 1,0,0,0,0,0,1,1);
        tbl[30] = mk(0,0,0,0,0,0,0,0,0,1,0,1, 1,0,0,0,0,0,1,1);
        tbl[31] = mk(0,0,0,0,0,0,0,0,0,1,0,0, 0,0,0,0,0,0,0,1);
        tbl[32] = mk(0,1,'h400,0,0,0,1,'h500,0,1,0,0, 0,1,'h500,1,0,0,0,1);
        tbl[33] = mk(0,0,0,0,0,0,0,0,0,1,0,0, 0,0,0,0,0,0,0,2);

        // Two plain reset cycles bring DUT and model to a known state.
        x = tbl[0].i;
        step(x);
        step(x);

        // Directed cycle table.
        for (int k = 0; k < 34; k++) begin
            step(tbl[k].i);
            chk($sformatf("tbl%0d.stall", k),  W'(stall_o),        W'(tbl[k].stall));
            chk($sformatf("tbl%0d.taken", k),  W'(is_taken_o),     W'(tbl[k].taken));
            chk($sformatf("tbl%0d.flush", k),  W'(flush_o),        W'(tbl[k].flush));
            chk($sformatf("tbl%0d.ack", k),    W'(trap_ack_o),     W'(tbl[k].ack));
            chk($sformatf("tbl%0d.halted", k), W'(halted_o),       W'(tbl[k].halted));
            chk($sformatf("tbl%0d.epc", k),    epc_o,              tbl[k].epc);
            chk($sformatf("tbl%0d.cnt", k),    W'(redirect_cnt_o), W'(tbl[k].cnt));
            if (tbl[k].taken)
                chk($sformatf("tbl%0d.pc", k), bru_pc_o, tbl[k].pc);
        end

        // Randomized traffic against the behavioural model.
        for (int k = 0; k < 2000; k++) begin
            x.rst   = ($urandom_range(0, 99) < 2);
            x.tk    = ($urandom_range(0, 99) < 30);
            x.tgt   = $urandom;
            x.trap  = ($urandom_range(0, 99) < 10);
            x.tpc   = $urandom;
            x.mtvec = $urandom;
            x.mret  = ($urandom_range(0, 99) < 10);
            x.mepc  = $urandom;
            x.hz    = ($urandom_range(0, 99) < 30);
            x.rdy   = ($urandom_range(0, 99) < 65);
            x.halt  = ($urandom_range(0, 99) < 10);
            x.res   = ($urandom_range(0, 99) < 20);
            step(x);
            chk("rnd.stall",  W'(stall_o),        W'(e_stall));
            chk("rnd.taken",  W'(is_taken_o),     W'(e_taken));
            chk("rnd.flush",  W'(flush_o),        W'(e_flush));
            chk("rnd.ack",    W'(trap_ack_o),     W'(e_ack));
            chk("rnd.halted", W'(halted_o),       W'(e_halted));
            chk("rnd.epc",    epc_o,              e_epc);
            chk("rnd.cnt",    W'(redirect_cnt_o), W'(e_cnt));
            if (e_taken)
                chk("rnd.pc", bru_pc_o, e_pc);
        end

        // Counter saturation: reset, then back-to-back taken branches.
        x = tbl[25].i;
        x.rst = 1'b1;
        step(x);
        x = tbl[1].i;
        for (int k = 0; k < 65537; k++) begin
            step(x);
            if (k == 65534)
                chk("sat.before", W'(redirect_cnt_o), W'(16'hFFFE));
        end
        step(x);
        chk("sat.hold1", W'(redirect_cnt_o), W'(16'hFFFF));
        chk("sat.taken", W'(is_taken_o), W'(1'b1));
        step(x);
        chk("sat.hold2", W'(redirect_cnt_o), W'(16'hFFFF));
        x = tbl[25].i;
        x.rst = 1'b1;
        step(x);
        x.rst = 1'b0;
        step(x);
        chk("sat.clear", W'(redirect_cnt_o), W'(16'h0000));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
